// File: rtl/bitty_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitty_pkg
// Brief    : Shared state encoding and instruction field codes for the Bitty
//            fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package bitty_pkg;

    localparam int INST_W = 16;
    localparam int WDOG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] FMT_BRANCH = 2'b10;

    localparam logic [1:0] COND_EQ    = 2'b00;
    localparam logic [1:0] COND_GT    = 2'b01;
    localparam logic [1:0] COND_LT    = 2'b10;
    localparam logic [1:0] COND_NEVER = 2'b11;

endpackage
`default_nettype wire

// File: rtl/bitty_inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : bitty_inst_mem
// Brief    : Single-port program RAM, synchronous read with a resettable
//            output register that doubles as the issued instruction.
// Revision : 1.0 - initial release
// ============================================================================
module bitty_inst_mem
    import bitty_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [INST_W-1:0] wdata,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register only loads on a read, so it holds the instruction steady
    // for the whole ISSUE/WAIT window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bitty_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : bitty_fetch_unit
// Brief    : Sequences a PC over program memory, issues instructions to the
//            Bitty core via run/done, and resolves branches locally.
// Revision : 1.0 - initial release
// ============================================================================
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic [2:0]        cond_flags,
    input  logic              done,
    output logic [INST_W-1:0] d_inst,
    output logic              run,
    output logic [AW:0]       pc,
    output logic              busy,
    output logic              finished,
    output logic              error
);

    state_t            state;
    logic [AW:0]       len_q;
    logic [WDOG_W-1:0] watchdog;

    logic              is_branch;
    logic              taken;
    logic [AW:0]       pc_inc;
    logic [AW:0]       pc_after;
    logic              pc_done;

    bitty_inst_mem #(
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      ((state == ST_IDLE) && load_en),
        .re      (state == ST_FETCH),
        .addr    ((state == ST_IDLE) ? load_addr : pc[AW-1:0]),
        .wdata   (load_data),
        .rdata   (d_inst)
    );

    always_comb begin
        is_branch = (d_inst[1:0] == FMT_BRANCH);
        case (d_inst[3:2])
            COND_EQ:    taken = cond_flags[2];
            COND_GT:    taken = cond_flags[1];
            COND_LT:    taken = cond_flags[0];
            COND_NEVER: taken = 1'b0;
            default:    taken = 1'b0;
        endcase
        pc_inc   = pc + {{AW{1'b0}}, 1'b1};
        pc_after = pc_inc;
        if ((state == ST_ISSUE) && is_branch && taken) begin
            pc_after = {1'b0, d_inst[4 +: AW]};
        end
        pc_done  = (pc_after >= len_q);
    end

    // The instruction word only becomes available at ISSUE entry, so run is
    // decoded from the registered state and the registered instruction.
    assign run = (state == ST_ISSUE) && !is_branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            len_q    <= '0;
            watchdog <= '0;
            busy     <= 1'b0;
            finished <= 1'b0;
            error    <= 1'b0;
        end else begin
            finished <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= prog_len;
                        pc    <= '0;
                        error <= 1'b0;
                        if (prog_len == '0) begin
                            finished <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    watchdog <= '0;
                    if (!is_branch) begin
                        state <= ST_WAIT;
                    end else begin
                        pc <= pc_after;
                        if (pc_done) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        pc <= pc_after;
                        if (pc_done) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else if (watchdog == WDOG_W'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitty_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitty_fetch_unit
// Brief    : Directed self-checking bench for bitty_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitty_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic [2:0]  cond_flags = '0;
    logic        done;
    logic [15:0] d_inst;
    logic        run;
    logic [4:0]  pc;
    logic        busy;
    logic        finished;
    logic        error;

    logic        core_en = 1'b0;
    logic        man_done = 1'b0;
    logic        auto_done = 1'b0;
    int          core_cnt = 0;
    logic [15:0] issued[$];
    int          fin_count = 0;

    int checks = 0;
    int errors = 0;

    assign done = auto_done | man_done;

    always #5 clk = ~clk;

    bitty_fetch_unit #(
        .AW      (4),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .prog_len   (prog_len),
        .start      (start),
        .cond_flags (cond_flags),
        .done       (done),
        .d_inst     (d_inst),
        .run        (run),
        .pc         (pc),
        .busy       (busy),
        .finished   (finished),
        .error      (error)
    );

    // Core model: done strobes two cycles after each run pulse.
    always @(posedge clk) begin
        auto_done <= 1'b0;
        if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) auto_done <= 1'b1;
        end else if (core_en && run) begin
            core_cnt <= 2;
        end
    end

    always @(posedge clk) begin
        if (run) issued.push_back(d_inst);
        if (finished) fin_count++;
    end

    task automatic load_word(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic start_prog(input logic [4:0] len);
        @(posedge clk); #1;
        start = 1'b1; prog_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_run(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (run) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_inst, run, pc, busy, finished, error} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got d_inst=%h run=%b pc=%0d busy=%b fin=%b err=%b, expected all 0",
                     d_inst, run, pc, busy, finished, error);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_program;
        bit ok;
        int r0, f0;
        logic [15:0] prog [3];
        prog[0] = 16'h1230; prog[1] = 16'h4564; prog[2] = 16'h78A8;
        for (int i = 0; i < 3; i++) load_word(4'(i), prog[i]);
        core_en = 1'b1;
        r0 = issued.size(); f0 = fin_count;
        start_prog(5'd3);
        wait_idle(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL alu_timeout: busy=%b, expected 0 within budget", busy); end
        checks++;
        if (issued.size() - r0 !== 3) begin
            errors++; $display("FAIL alu_run_count: got %0d, expected 3", issued.size() - r0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r0 + i >= issued.size() || issued[r0 + i] !== prog[i]) begin
                errors++;
                $display("FAIL alu_inst%0d: got %h, expected %h", i,
                         (r0 + i < issued.size()) ? issued[r0 + i] : 16'hxxxx, prog[i]);
            end
        end
        checks++;
        if (fin_count - f0 !== 1) begin errors++; $display("FAIL alu_finished: got %0d pulses, expected 1", fin_count - f0); end
        checks++;
        if (pc !== 5'd3 || busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL alu_final: got pc=%0d busy=%b err=%b, expected pc=3 busy=0 err=0", pc, busy, error);
        end
    endtask

    task automatic test_branch(input logic [2:0] flags, input int exp_n,
                               input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        bit ok;
        int r0;
        logic [15:0] exp_q [3];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2;
        load_word(4'd0, 16'h0010);
        load_word(4'd1, 16'h0032);
        load_word(4'd2, 16'h0B0C);
        load_word(4'd3, 16'h0D01);
        core_en = 1'b1;
        cond_flags = flags;
        r0 = issued.size();
        start_prog(5'd4);
        wait_idle(80, ok);
        checks++;
        if (!ok || issued.size() - r0 !== exp_n) begin
            errors++; $display("FAIL branch_%b_count: got %0d runs (idle=%b), expected %0d", flags, issued.size() - r0, ok, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (r0 + i >= issued.size() || issued[r0 + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL branch_%b_inst%0d: got %h, expected %h", flags, i,
                         (r0 + i < issued.size()) ? issued[r0 + i] : 16'hxxxx, exp_q[i]);
            end
        end
        checks++;
        if (pc !== 5'd4) begin errors++; $display("FAIL branch_%b_pc: got %0d, expected 4", flags, pc); end
    endtask

    task automatic test_zero_len;
        int r0, f0;
        r0 = issued.size(); f0 = fin_count;
        start_prog(5'd0);
        checks++;
        if (finished !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_len_pulse: got fin=%b busy=%b, expected fin=1 busy=0", finished, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (issued.size() != r0 || fin_count - f0 !== 1 || pc !== 5'd0) begin
            errors++; $display("FAIL zero_len_after: got runs=%0d fins=%0d pc=%0d, expected 0 1 0",
                               issued.size() - r0, fin_count - f0, pc);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int f0;
        load_word(4'd0, 16'h0100);
        core_en = 1'b0;
        f0 = fin_count;
        start_prog(5'd1);
        wait_run(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_run: run not seen, expected run within 10 cycles"); end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got err=%b busy=%b after 14 WAIT cycles, expected err=0 busy=1", error, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_flag: got err=%b busy=%b after 15 WAIT cycles, expected err=1 busy=0", error, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fin_count != f0 || error !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got fins=%0d err=%b, expected 0 and 1", fin_count - f0, error);
        end
        core_en = 1'b1;
        start_prog(5'd1);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear: got err=%b after start, expected 0", error); end
        wait_idle(40, ok);
        checks++;
        if (!ok || fin_count - f0 !== 1) begin
            errors++; $display("FAIL timeout_rerun: got idle=%b fins=%0d, expected 1 1", ok, fin_count - f0);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        int r0;
        load_word(4'd0, 16'h2220);
        core_en = 1'b0;
        start_prog(5'd2);
        wait_run(10, ok);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || {d_inst, run, pc, busy, finished, error} !== 26'd0) begin
            errors++; $display("FAIL reset_mid_wait: got d_inst=%h run=%b pc=%0d busy=%b fin=%b err=%b (run_seen=%b), expected all 0",
                               d_inst, run, pc, busy, finished, error, ok);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        r0 = issued.size();
        @(posedge clk); #1;
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pc !== 5'd0 || issued.size() != r0) begin
            errors++; $display("FAIL reset_done_ignored: got busy=%b pc=%0d runs=%0d, expected 0 0 0", busy, pc, issued.size() - r0);
        end
        core_en = 1'b1;
        start_prog(5'd1);
        wait_idle(40, ok);
        checks++;
        if (!ok || issued.size() - r0 !== 1 || issued[issued.size() - 1] !== 16'h2220 || pc !== 5'd1) begin
            errors++; $display("FAIL reset_restart: got idle=%b runs=%0d pc=%0d, expected 1 1 1", ok, issued.size() - r0, pc);
        end
    endtask

    task automatic test_busy_ignore;
        bit ok;
        int r0;
        load_word(4'd0, 16'h0100);
        load_word(4'd1, 16'h0204);
        load_word(4'd2, 16'h0308);
        core_en = 1'b1;
        r0 = issued.size();
        start_prog(5'd3);
        @(posedge clk); #1;
        start = 1'b1; prog_len = 5'd1;
        load_en = 1'b1; load_addr = 4'd2; load_data = 16'hFFFC;
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        wait_idle(60, ok);
        checks++;
        if (!ok || issued.size() - r0 !== 3 || pc !== 5'd3) begin
            errors++; $display("FAIL busy_no_restart: got idle=%b runs=%0d pc=%0d, expected 1 3 3", ok, issued.size() - r0, pc);
        end
        checks++;
        if (issued.size() - r0 < 3 || issued[r0 + 2] !== 16'h0308) begin
            errors++; $display("FAIL busy_mem_unchanged: got %h, expected 0308",
                               (issued.size() - r0 >= 3) ? issued[r0 + 2] : 16'hxxxx);
        end
        r0 = issued.size();
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pc !== 5'd3 || issued.size() != r0) begin
            errors++; $display("FAIL stray_done: got busy=%b pc=%0d runs=%0d, expected 0 3 0", busy, pc, issued.size() - r0);
        end
    endtask

    initial begin
        test_reset();
        test_alu_program();
        test_branch(3'b100, 2, 16'h0010, 16'h0D01, 16'h0000);
        test_branch(3'b010, 3, 16'h0010, 16'h0B0C, 16'h0D01);
        test_zero_len();
        test_timeout();
        test_reset_mid_wait();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
